// File: rtl/vga_timing_ctrl.sv
// VGA raster timing from a single clock using a one-cycle pixel enable every DIV clocks.
// Optional 8-bit frame counter output is built when VGA_FRAME_CNT_EN is defined.
module vga_timing_ctrl #(
  parameter int DIV      = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CNT_W    = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic             PIXTICK,
  output logic [CNT_W-1:0] HCNT,
  output logic [CNT_W-1:0] VCNT,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             VIDEO_ON,
`ifdef VGA_FRAME_CNT_EN
  output logic [7:0]       FRAME_CNT,
`endif
  output logic             FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [4:0]       DIV_LAST = 5'(DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [4:0]       r_div;
  logic             r_pixtick;
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_vcnt;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_video_on;
  logic             r_frame_start;

  logic [4:0]       w_div_nxt;
  logic             w_tick_nxt;
  logic [CNT_W-1:0] w_h_nxt;
  logic [CNT_W-1:0] w_v_nxt;
  logic             w_fs_nxt;
  logic             w_hsync_nxt;
  logic             w_vsync_nxt;
  logic             w_video_nxt;

  always_comb begin
    w_div_nxt  = (r_div == DIV_LAST) ? 5'd0 : r_div + 5'd1;
    w_tick_nxt = (w_div_nxt == DIV_LAST);
    w_h_nxt    = r_hcnt;
    w_v_nxt    = r_vcnt;
    w_fs_nxt   = 1'b0;
    // Raster moves only on the edge that ends a PIXTICK cycle.
    if (r_pixtick) begin
      if (r_hcnt == H_LAST) begin
        w_h_nxt = '0;
        if (r_vcnt == V_LAST) begin
          w_v_nxt  = '0;
          w_fs_nxt = 1'b1;
        end else begin
          w_v_nxt = r_vcnt + 1'b1;
        end
      end else begin
        w_h_nxt = r_hcnt + 1'b1;
      end
    end
    // Decoded from next-state counters so they line up with HCNT/VCNT.
    w_video_nxt = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
    w_hsync_nxt = !((w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END));
    w_vsync_nxt = !((w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END));
  end

  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      r_div         <= '0;
      r_pixtick     <= 1'b0;
      r_hcnt        <= '0;
      r_vcnt        <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_video_on    <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= w_div_nxt;
      r_pixtick     <= w_tick_nxt;
      r_hcnt        <= w_h_nxt;
      r_vcnt        <= w_v_nxt;
      r_hsync       <= w_hsync_nxt;
      r_vsync       <= w_vsync_nxt;
      r_video_on    <= w_video_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge CLK) begin
    if (RST || !EN) begin
      r_frame_cnt <= 8'd0;
    end else if (w_fs_nxt) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign FRAME_CNT = r_frame_cnt;
`endif

  assign PIXTICK     = r_pixtick;
  assign HCNT        = r_hcnt;
  assign VCNT        = r_vcnt;
  assign HSYNC       = r_hsync;
  assign VSYNC       = r_vsync;
  assign VIDEO_ON    = r_video_on;
  assign FRAME_START = r_frame_start;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunk raster (8x7 positions, DIV=4).
// Define VGA_FRAME_CNT_EN to also exercise the frame counter.
module tb_vga_timing_ctrl;

  localparam int DIV = 4;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       pixtick, hsync, vsync, video_on, frame_start;
  logic [9:0] hcnt, vcnt;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int c = 0;

  vga_timing_ctrl #(
    .DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .CNT_W(10)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .EN(en),
    .PIXTICK(pixtick),
    .HCNT(hcnt),
    .VCNT(vcnt),
    .HSYNC(hsync),
    .VSYNC(vsync),
    .VIDEO_ON(video_on),
`ifdef VGA_FRAME_CNT_EN
    .FRAME_CNT(frame_cnt),
`endif
    .FRAME_START(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected outputs after cc enabled edges since idle/reset, in closed form.
  function automatic logic [31:0] exp_vec(input int cc);
    int t, p, h, v;
    logic pix, hs, vs, vo, fs;
    if (cc == 0) return {7'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    t   = cc / DIV;
    p   = t % (HT * VT);
    h   = p % HT;
    v   = p / HT;
    pix = (cc % DIV) == DIV - 1;
    vo  = (h < HA) && (v < VA);
    hs  = !((h >= HA + HF) && (h < HA + HF + HS));
    vs  = !((v >= VA + VF) && (v < VA + VF + VS));
    fs  = (cc % DIV == 0) && (p == 0) && (t > 0);
    return {7'd0, pix, 10'(h), 10'(v), hs, vs, vo, fs};
  endfunction

  function automatic logic [31:0] obs_vec();
    return {7'd0, pixtick, hcnt, vcnt, hsync, vsync, video_on, frame_start};
  endfunction

  task automatic step();
    logic e_rst, e_en;
    e_rst = rst;
    e_en  = en;
    @(posedge clk);
    #1;
    if (e_rst || !e_en) c = 0;
    else c++;
    check_eq("cycle_model", obs_vec(), exp_vec(c));
  endtask

  task automatic wait_pos(input int h, input int v);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      step();
      if (hcnt == 10'(h) && vcnt == 10'(v)) found = 1'b1;
    end
    check_eq("wait_pos", {31'd0, found}, 32'd1);
  endtask

  initial begin
    int n_pix, n_hs, n_vs, n_vo, n_fs;
    logic found;
    n_pix = 0; n_hs = 0; n_vs = 0; n_vo = 0; n_fs = 0;

    // Reset held three cycles with EN low.
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_hsync", {31'd0, hsync}, 32'd1);
      check_eq("rst_video", {31'd0, video_on}, 32'd0);
    end

    rst = 1'b0;
    en  = 1'b1;
    for (int i = 1; i <= FRAME_CLK; i++) begin
      step();
      n_pix += int'(pixtick);
      n_hs  += int'(!hsync);
      n_vs  += int'(!vsync);
      n_vo  += int'(video_on);
      n_fs  += int'(frame_start);
      if (i == 2)   check_eq("pix_early", {31'd0, pixtick}, 32'd0);
      if (i == 3)   check_eq("pix_first", {31'd0, pixtick}, 32'd1);
      if (i == 4)   check_eq("h_after_tick", {22'd0, hcnt}, 32'd1);
      if (i == 19)  check_eq("hsync_pre", {31'd0, hsync}, 32'd1);
      if (i == 20)  check_eq("hsync_start", {31'd0, hsync}, 32'd0);
      if (i == 28)  check_eq("hsync_end", {31'd0, hsync}, 32'd1);
      if (i == 32)  check_eq("line_wrap", {12'd0, hcnt, vcnt}, {12'd0, 10'd0, 10'd1});
      if (i == 223) check_eq("frame_last", {11'd0, frame_start, hcnt, vcnt}, {11'd0, 1'b0, 10'd7, 10'd6});
      if (i == 224) check_eq("frame_wrap", {11'd0, frame_start, hcnt, vcnt}, {11'd0, 1'b1, 10'd0, 10'd0});
    end
    check_eq("n_pixtick", n_pix, 32'd56);
    check_eq("n_hsync_low", n_hs, 32'd56);
    check_eq("n_vsync_low", n_vs, 32'd64);
    check_eq("n_video_on", n_vo, 32'd48);
    check_eq("n_frame_start", n_fs, 32'd1);

    // Drop EN mid-frame, hold idle, then restart.
    wait_pos(3, 2);
    en = 1'b0;
    step();
    check_eq("idle_vec", obs_vec(), {7'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int i = 0; i < 5; i++) step();
    check_eq("idle_hold_h", {22'd0, hcnt}, 32'd0);
    en = 1'b1;
    step();
    step();
    check_eq("restart_pix_early", {31'd0, pixtick}, 32'd0);
    step();
    check_eq("restart_pix", {31'd0, pixtick}, 32'd1);
    step();
    check_eq("restart_h", {12'd0, hcnt, vcnt}, {12'd0, 10'd1, 10'd0});

    // Reset while running inside the VSYNC region.
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK && !found; i++) begin
      step();
      if (!vsync) found = 1'b1;
    end
    check_eq("reach_vsync", {31'd0, found}, 32'd1);
    rst = 1'b1;
    step();
    check_eq("rst_vsync", {31'd0, vsync}, 32'd1);
    check_eq("rst_vec", obs_vec(), {7'd0, 1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();

`ifdef VGA_FRAME_CNT_EN
    rst = 1'b1;
    step();
    check_eq("fcnt_rst", {24'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < FRAME_CLK; i++) step();
    check_eq("fcnt_one", {24'd0, frame_cnt}, 32'd1);
    for (int i = 0; i < 256 * FRAME_CLK; i++) step();
    check_eq("fcnt_wrap", {24'd0, frame_cnt}, 32'd1);
    en = 1'b0;
    step();
    check_eq("fcnt_idle", {24'd0, frame_cnt}, 32'd0);
    en = 1'b1;
    for (int i = 0; i < FRAME_CLK; i++) step();
    rst = 1'b1;
    step();
    check_eq("fcnt_rst2", {24'd0, frame_cnt}, 32'd0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
